instr_fetch_stage: RTL and testbench

//   IF stage of the 5-stage pipeline: owns the program counter, drives the byte address into the

---
 rtl/instr_fetch_stage.sv | 92 +++++++++
 tb/tb_instr_fetch_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - IF stage: PC register, ROM address drive, IF/ID capture, fetch fault
module instr_fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [63:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        pc_fault
);

    localparam logic [64:0] IMEM_LIMIT = 65'(IMEM_BYTES);

    logic [63:0] pc_q, pc_d;
    logic [63:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        pc_fault_q, pc_fault_d;
    logic        pc_legal;

    // Extended to 65 bits so a PC near the top of the address space cannot wrap into range.
    assign pc_legal = (pc_q[1:0] == 2'b00) && (({1'b0, pc_q} + 65'd3) < IMEM_LIMIT);

    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        pc_fault_d   = pc_fault_q;

        if (pc_fault_q) begin
            ifid_pc_d    = 64'd0;
            ifid_instr_d = 32'd0;
            ifid_valid_d = 1'b0;
        end else begin
            if (br_taken) begin
                pc_d = br_target;
            end else if (!stall) begin
                pc_d = pc_q + 64'd4;
            end

            if (flush || br_taken) begin
                ifid_pc_d    = 64'd0;
                ifid_instr_d = 32'd0;
                ifid_valid_d = 1'b0;
            end else if (!stall) begin
                if (pc_legal) begin
                    ifid_pc_d    = pc_q;
                    ifid_instr_d = imem_instr;
                    ifid_valid_d = 1'b1;
                end else begin
                    // The ROM word is meaningless here; take a bubble so no X enters the pipe.
                    ifid_pc_d    = 64'd0;
                    ifid_instr_d = 32'd0;
                    ifid_valid_d = 1'b0;
                    pc_fault_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 64'd0;
            ifid_instr_q <= 32'd0;
            ifid_valid_q <= 1'b0;
            pc_fault_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            pc_fault_q   <= pc_fault_d;
        end
    end

    assign imem_addr  = pc_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_valid = ifid_valid_q;
    assign pc_fault   = pc_fault_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - randomized and directed bench for instr_fetch_stage against a reference model
module tb_instr_fetch_stage;

    localparam int unsigned IMEM = 256;
    localparam logic [63:0] RPC  = 64'd0;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        reset, stall, flush, br_taken;
    logic [63:0] br_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        pc_fault;

    logic [31:0] rom [IMEM/4];

    logic [63:0] m_pc, m_ifid_pc;
    logic [31:0] m_ifid_instr;
    logic        m_valid, m_fault;

    int errors = 0;
    int checks = 0;

    instr_fetch_stage #(.RESET_PC(RPC), .IMEM_BYTES(IMEM)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .br_taken(br_taken), .br_target(br_target), .imem_addr(imem_addr),
        .imem_instr(imem_instr), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
        .ifid_valid(ifid_valid), .pc_fault(pc_fault)
    );

    always #5 clk = ~clk;

    function automatic bit ref_legal(input logic [63:0] a);
        return (a % 64'd4 == 64'd0) && (({1'b0, a} + 65'd3) < 65'(IMEM));
    endfunction

    // ROM model: junk word on illegal addresses so an erroneous capture is visible.
    always_comb begin
        imem_instr = JUNK;
        if (ref_legal(imem_addr)) imem_instr = rom[int'(imem_addr >> 2)];
    end

    task automatic model_update();
        logic [63:0] fetched_pc;
        logic        fetch_wanted;
        fetched_pc   = m_pc;
        fetch_wanted = !stall && !flush && !br_taken;
        if (reset) begin
            m_pc = RPC; m_ifid_pc = 0; m_ifid_instr = 0; m_valid = 0; m_fault = 0;
        end else if (m_fault) begin
            m_ifid_pc = 0; m_ifid_instr = 0; m_valid = 0;
        end else begin
            m_pc = br_taken ? br_target : (stall ? m_pc : m_pc + 64'd4);
            if (flush || br_taken) begin
                m_ifid_pc = 0; m_ifid_instr = 0; m_valid = 0;
            end else if (fetch_wanted && ref_legal(fetched_pc)) begin
                m_ifid_pc = fetched_pc; m_ifid_instr = rom[int'(fetched_pc >> 2)]; m_valid = 1;
            end else if (fetch_wanted) begin
                m_ifid_pc = 0; m_ifid_instr = 0; m_valid = 0; m_fault = 1;
            end
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic b, input logic [63:0] t);
        reset = r; stall = s; flush = f; br_taken = b; br_target = t;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 1, 64'd52);
        tick();
        tick();
        checks++; if (imem_addr !== RPC) begin errors++; $display("FAIL reset_pc got=%0h exp=%0h", imem_addr, RPC); end
        checks++; if (ifid_valid !== 1'b0 || ifid_pc !== 64'd0 || ifid_instr !== 32'd0)
            begin errors++; $display("FAIL reset_ifid got v=%0b pc=%0h i=%0h exp 0", ifid_valid, ifid_pc, ifid_instr); end
        checks++; if (pc_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%0b exp=0", pc_fault); end
    endtask

    task automatic test_sequential();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (ifid_pc !== 64'(4 * i) || ifid_valid !== 1'b1)
                begin errors++; $display("FAIL seq_pc%0d got pc=%0h v=%0b exp pc=%0h v=1", i, ifid_pc, ifid_valid, 4 * i); end
            checks++; if (ifid_instr !== rom[i]) begin errors++; $display("FAIL seq_instr%0d got=%0h exp=%0h", i, ifid_instr, rom[i]); end
        end
    endtask

    task automatic test_stall();
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (imem_addr !== 64'd16 || ifid_pc !== 64'd12)
                begin errors++; $display("FAIL stall%0d got addr=%0h ifid_pc=%0h exp 10/c", i, imem_addr, ifid_pc); end
        end
        drive(0, 0, 0, 0, 0);
        tick();
        checks++; if (ifid_pc !== 64'd16 || ifid_instr !== rom[4]) begin errors++; $display("FAIL stall_rel1 got=%0h exp=10", ifid_pc); end
        tick();
        checks++; if (ifid_pc !== 64'd20) begin errors++; $display("FAIL stall_rel2 got=%0h exp=14", ifid_pc); end
    endtask

    task automatic test_branch();
        checks++; if (imem_addr !== 64'd24) begin errors++; $display("FAIL br_setup got=%0h exp=18", imem_addr); end
        drive(0, 1, 0, 1, 64'd100);
        tick();
        checks++; if (imem_addr !== 64'd100 || ifid_valid !== 1'b0)
            begin errors++; $display("FAIL br_redirect got addr=%0h v=%0b exp 64/0", imem_addr, ifid_valid); end
        drive(0, 0, 0, 0, 0);
        tick();
        checks++; if (ifid_pc !== 64'd100 || ifid_valid !== 1'b1 || ifid_instr !== rom[25])
            begin errors++; $display("FAIL br_target got pc=%0h v=%0b exp 64/1", ifid_pc, ifid_valid); end
    endtask

    task automatic test_flush_stall();
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick();
        drive(0, 1, 1, 0, 0); tick();
        checks++; if (ifid_valid !== 1'b0 || imem_addr !== 64'd40)
            begin errors++; $display("FAIL flush_stall got v=%0b addr=%0h exp 0/28", ifid_valid, imem_addr); end
        drive(0, 0, 0, 0, 0); tick();
        checks++; if (ifid_pc !== 64'd40 || ifid_valid !== 1'b1) begin errors++; $display("FAIL flush_release got=%0h exp=28", ifid_pc); end
    endtask

    task automatic test_overrun();
        logic [63:0] frozen;
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < IMEM / 4 + 4 && m_pc != 64'(IMEM - 4); i++) tick();
        checks++; if (imem_addr !== 64'(IMEM - 4)) begin errors++; $display("FAIL ovr_reach got=%0h exp=%0h", imem_addr, IMEM - 4); end
        tick();
        checks++; if (imem_addr !== 64'(IMEM) || pc_fault !== 1'b0 || ifid_instr !== rom[IMEM/4-1])
            begin errors++; $display("FAIL ovr_last got addr=%0h f=%0b exp %0h/0", imem_addr, pc_fault, IMEM); end
        tick();
        checks++; if (pc_fault !== 1'b1 || ifid_valid !== 1'b0 || ifid_instr !== 32'd0)
            begin errors++; $display("FAIL ovr_fault got f=%0b v=%0b i=%0h exp 1/0/0", pc_fault, ifid_valid, ifid_instr); end
        frozen = m_pc;
        drive(0, 0, 0, 1, 64'd8); tick(); tick();
        checks++; if (imem_addr !== frozen || pc_fault !== 1'b1 || ifid_valid !== 1'b0)
            begin errors++; $display("FAIL ovr_frozen got addr=%0h f=%0b exp %0h/1", imem_addr, pc_fault, frozen); end
        drive(1, 0, 0, 0, 0); tick();
        checks++; if (imem_addr !== RPC || pc_fault !== 1'b0) begin errors++; $display("FAIL ovr_reset got addr=%0h f=%0b exp 0/0", imem_addr, pc_fault); end
    endtask

    task automatic test_misaligned();
        drive(0, 0, 0, 1, 64'd6); tick();
        checks++; if (imem_addr !== 64'd6 || pc_fault !== 1'b0) begin errors++; $display("FAIL mis_redirect got addr=%0h f=%0b exp 6/0", imem_addr, pc_fault); end
        drive(0, 0, 0, 0, 0); tick();
        checks++; if (pc_fault !== 1'b1 || ifid_instr !== 32'd0 || ifid_valid !== 1'b0)
            begin errors++; $display("FAIL mis_fault got f=%0b i=%0h v=%0b exp 1/0/0", pc_fault, ifid_instr, ifid_valid); end
    endtask

    task automatic test_random();
        logic [63:0] t;
        int sel;
        drive(1, 0, 0, 0, 0); tick();
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 9);
            t = (sel < 8) ? 64'($urandom_range(0, IMEM / 4 - 1) * 4)
              : (sel == 8) ? 64'($urandom_range(0, IMEM - 1)) : {$urandom, $urandom};
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0, t);
            tick();
            checks++;
            if (imem_addr !== m_pc || ifid_pc !== m_ifid_pc || ifid_instr !== m_ifid_instr ||
                ifid_valid !== m_valid || pc_fault !== m_fault) begin
                errors++;
                $display("FAIL rand%0d got pc=%0h ipc=%0h i=%0h v=%0b f=%0b exp pc=%0h ipc=%0h i=%0h v=%0b f=%0b",
                         n, imem_addr, ifid_pc, ifid_instr, ifid_valid, pc_fault,
                         m_pc, m_ifid_pc, m_ifid_instr, m_valid, m_fault);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < IMEM / 4; i++) rom[i] = $urandom;
        m_pc = RPC; m_ifid_pc = 0; m_ifid_instr = 0; m_valid = 0; m_fault = 0;
        drive(1, 0, 0, 0, 0);
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_flush_stall();
        test_overrun();
        test_misaligned();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
